mod997_residue_accumulator: RTL and testbench
=============================================

# mod997_residue_accumulator

Sequential reduction stage directly downstream of the mod-997 chunk LUTs in the x_500 datapath. Each 6-input LUT turns one 6-bit chunk of a 500-bit operand into a 10-bit residue. This block takes those residues one per cycle over a valid/ready stream and accumulates them modulo 997. At the end of each frame it emits the final 10-bit residue of the whole operand, together with a term count and a sticky error flag.

## Interface

Parameters:
- MOD, 997, modulus; must satisfy 2 ≤ MOD < 2^W.
- W, 10, residue width.
- N_TERMS, 84, maximum terms per frame (ceil(500/6)).
- CW, 7, term-counter width; must satisfy 2^CW > N_TERMS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream term valid.
- in_ready  output  1  block accepts a term this cycle.
- in_residue  input  W  LUT residue, nominally < MOD.
- in_last  input  1  current term is the last of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_residue  output  W  frame sum mod MOD.
- out_count  output  CW  number of terms in the frame.
- out_err  output  1  frame saw an out-of-range term or a term-count overflow.

## Operation

States:
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.

Accept and arithmetic:
- A term is accepted when in_valid & in_ready.
- Pre-reduce: r' = in_residue − MOD if in_residue ≥ MOD, else in_residue. When in_residue ≥ MOD, set the frame error bit. Result r' < MOD holds for W=10 / MOD=997.
- Sum: s = acc + r', computed W+1 bits wide; s' = s − MOD if s ≥ MOD, else s. No other reduction path.
- Term counter cnt increments on each accepted term.
- If an accept occurs with cnt == N_TERMS, set the frame error bit and saturate cnt at N_TERMS.

Transitions:
- ACCUM, accept with in_last=0: acc ← s', stay in ACCUM.
- ACCUM, accept with in_last=1: out_residue ← s', out_count ← cnt+1 (saturating), out_err ← frame error OR this term's error. Clear acc, cnt and the frame error bit. Go to HOLD.
- HOLD, out_ready=1: go to ACCUM. out_residue, out_count and out_err keep their values until the next frame result overwrites them.
- HOLD, out_ready=0: hold all outputs stable.
- ACCUM, no accept: all registers hold.

Boundary conditions:
- A frame of length 1 (in_last on the first term) is legal: out_residue = r'.
- in_residue, in_last and in_valid are ignored while in_ready=0.

Reset:
- rst asserted at any time, including mid-frame or in HOLD: immediately acc=0, cnt=0, error bit=0, out_valid=0, out_residue=0, out_count=0, out_err=0, state=ACCUM.
- in_ready is forced 0 while rst=1 and becomes 1 in the first cycle after deassertion.
- A partial frame is discarded with no output.

## Timing

- Throughput: one term per cycle within a frame.
- Latency: last term accepted at edge t → out_valid=1 from edge t through the edge where out_ready is sampled high.
- Minimum gap between frames: out_valid to the next accept is ≥1 cycle. in_ready rises in the cycle after the out handshake; there is no combinational ready-to-ready path.
- All outputs are registered except in_ready, which is decoded from state and rst.
- Critical path: pre-reduce subtract → add → compare/subtract, all in one cycle.

## Test plan

- Wrap: terms 996, then 1 with in_last → out_residue=0, out_count=2, out_err=0.
- Multi-term: 500, 500, 500 (last) at one term per cycle → out_valid one edge after the last accept, out_residue=503, out_count=3.
- Out-of-range: single term 1000 with in_last → out_residue=3, out_count=1, out_err=1. The next frame (5 last) → out_residue=5, out_err=0.
- Backpressure: after a frame with result 503, hold out_ready=0 for 5 cycles → out_valid, out_residue=503 and in_ready=0 stay stable. Raise out_ready → in_ready=1 the next cycle and the next frame starts from acc=0.
- Overflow: 85 terms of value 1 with in_last on the 85th → out_count=84, out_err=1, out_residue=85.
- Reset mid-frame: accept 700, 700, assert rst for one cycle, then send 10 with in_last → out_residue=10, out_count=1. While rst=1: in_ready=0 and out_valid=0.

Source files
------------

// File: rtl/mod997_residue_accumulator_if.sv
// Term/result stream bundle for the mod-997 residue accumulator.
// Master drives terms and result ready; slave is the accumulator.
interface mod997_residue_accumulator_if #(
  parameter int W  = 10,
  parameter int CW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_residue;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_residue;
  logic [CW-1:0] out_count;
  logic          out_err;

  modport master (
    output in_valid, in_residue, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_count, out_err
  );

  modport slave (
    input  in_valid, in_residue, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_count, out_err
  );
endinterface

// File: rtl/mod997_residue_accumulator.sv
// Accumulates one LUT residue per cycle modulo MOD and emits a per-frame
// residue, term count and sticky error flag on a valid/ready result port.
module mod997_residue_accumulator #(
  parameter int MOD     = 997,
  parameter int W       = 10,
  parameter int N_TERMS = 84,
  parameter int CW      = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  mod997_residue_accumulator_if.slave       bus
);

  localparam logic [0:0]    ST_ACCUM  = 1'b0;
  localparam logic [0:0]    ST_HOLD   = 1'b1;
  localparam logic [W-1:0]  MOD_W     = MOD[W-1:0];
  localparam logic [W:0]    MOD_W1    = MOD[W:0];
  localparam logic [CW-1:0] N_TERMS_C = N_TERMS[CW-1:0];

  logic [0:0]    r_state;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [W-1:0]  r_out_residue;
  logic [CW-1:0] r_out_count;
  logic          r_out_err;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_term_err;
  logic          w_cnt_full;
  logic [W-1:0]  w_r_pre;
  logic [W:0]    w_sum;
  logic [W:0]    w_sum_sub;
  logic [W-1:0]  w_sum_red;
  logic [CW-1:0] w_cnt_next;

  // in_ready is the only unregistered output: it drops during reset.
  assign w_in_ready = (r_state == ST_ACCUM) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_term_err = 1'b0;
    w_r_pre    = bus.in_residue;
    if (bus.in_residue >= MOD_W) begin
      w_term_err = 1'b1;
      w_r_pre    = bus.in_residue - MOD_W;
    end
    w_sum      = {1'b0, r_acc} + {1'b0, w_r_pre};
    w_sum_sub  = w_sum - MOD_W1;
    w_sum_red  = (w_sum >= MOD_W1) ? w_sum_sub[W-1:0] : w_sum[W-1:0];
    w_cnt_full = (r_cnt == N_TERMS_C);
    w_cnt_next = w_cnt_full ? r_cnt : r_cnt + CW'(1);
  end

  // NOTE: all state uses non-blocking assignments; the reset branch clears
  // every register, including the held result, so a reset never leaks a stale frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_ACCUM;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      r_out_residue <= '0;
      r_out_count   <= '0;
      r_out_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (bus.in_last) begin
              r_out_residue <= w_sum_red;
              r_out_count   <= w_cnt_next;
              r_out_err     <= r_err | w_term_err | w_cnt_full;
              r_acc         <= '0;
              r_cnt         <= '0;
              r_err         <= 1'b0;
              r_state       <= ST_HOLD;
            end else begin
              r_acc <= w_sum_red;
              r_cnt <= w_cnt_next;
              r_err <= r_err | w_term_err | w_cnt_full;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == ST_HOLD);
  assign bus.out_residue = r_out_residue;
  assign bus.out_count   = r_out_count;
  assign bus.out_err     = r_out_err;

endmodule

// File: tb/tb_mod997_residue_accumulator.sv
// Directed bench for mod997_residue_accumulator with hand-computed frame results.
module tb_mod997_residue_accumulator;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  mod997_residue_accumulator_if #(.W(10), .CW(7)) bus ();

  mod997_residue_accumulator #(
    .MOD(997), .W(10), .N_TERMS(84), .CW(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one term; returns #1 after the accepting edge.
  task automatic send(input logic [9:0] v, input logic last);
    int n;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_residue = v;
    bus.in_last    = last;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Waits for a result, checks it, then completes the handshake.
  task automatic get_result(input string tag, input logic [9:0] res,
                            input logic [6:0] cnt, input logic err);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"},   32'(bus.out_residue), 32'(res));
    check({tag, "_cnt"},   32'(bus.out_count), 32'(cnt));
    check({tag, "_err"},   32'(bus.out_err), 32'(err));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_residue = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", 32'(bus.out_residue), 32'd0);
    check("rst_out_cnt", 32'(bus.out_count), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Wrap: 996 + 1 = 997 -> 0
    send(10'd996, 1'b0);
    send(10'd1, 1'b1);
    get_result("wrap", 10'd0, 7'd2, 1'b0);

    // Multi-term back to back: 500*3 mod 997 = 503, valid right after last accept
    send(10'd500, 1'b0);
    send(10'd500, 1'b0);
    send(10'd500, 1'b1);
    check("multi_latency", 32'(bus.out_valid), 32'd1);
    get_result("multi", 10'd503, 7'd3, 1'b0);

    // Out-of-range single term, then a clean frame clears the flag
    send(10'd1000, 1'b1);
    get_result("oor", 10'd3, 7'd1, 1'b1);
    send(10'd5, 1'b1);
    get_result("oor_next", 10'd5, 7'd1, 1'b0);

    // Exactly MOD pre-reduces to 0 and flags error
    send(10'd997, 1'b0);
    send(10'd4, 1'b1);
    get_result("eq_mod", 10'd4, 7'd2, 1'b1);

    // Backpressure with a term waiting that must not be taken
    send(10'd500, 1'b0);
    send(10'd500, 1'b0);
    send(10'd500, 1'b1);
    bus.in_valid   = 1'b1;
    bus.in_residue = 10'd77;
    bus.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_res", 32'(bus.out_residue), 32'd503);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_res_kept", 32'(bus.out_residue), 32'd503);
    send(10'd7, 1'b1);
    get_result("bp_next", 10'd7, 7'd1, 1'b0);

    // Full-length frame of 84 ones: no overflow
    for (int i = 0; i < 84; i++) send(10'd1, (i == 83));
    get_result("full84", 10'd84, 7'd84, 1'b0);

    // Overflow: 85 ones saturates count and flags error
    for (int i = 0; i < 85; i++) send(10'd1, (i == 84));
    get_result("ovf", 10'd85, 7'd84, 1'b1);

    // Reset while holding a result clears the result port
    send(10'd42, 1'b1);
    check("hold_pre_rst", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("hold_rst_valid", 32'(bus.out_valid), 32'd0);
    check("hold_rst_res", 32'(bus.out_residue), 32'd0);
    check("hold_rst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-frame discards the partial sum
    send(10'd700, 1'b0);
    send(10'd700, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", 32'(bus.in_ready), 32'd1);
    send(10'd10, 1'b1);
    get_result("mid_rst", 10'd10, 7'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
